// File: rtl/lwc_pkg.sv
// Shared constants for the LWC datapath: instruction opcodes, segment type
// codes, status words, the post-processor state type and the byte-mask
// helpers used on the bdo -> do path.
//
// No ports (package).
package lwc_pkg;

    // Instruction opcodes, cmd[31:28]
    localparam logic [3:0] OP_ACTKEY = 4'b0111;
    localparam logic [3:0] OP_ENC    = 4'b0010;
    localparam logic [3:0] OP_DEC    = 4'b0011;

    // Segment type codes, header[31:28]
    localparam logic [3:0] AD_TYPE   = 4'b0001;
    localparam logic [3:0] PT_TYPE   = 4'b0100;
    localparam logic [3:0] CT_TYPE   = 4'b0101;
    localparam logic [3:0] TAG_TYPE  = 4'b1000;

    // Status words returned to the host at the end of an operation
    localparam logic [31:0] STATUS_SUCCESS = 32'hE000_0000;
    localparam logic [31:0] STATUS_FAILURE = 32'hF000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_HDR,
        ST_OUT_HDR,
        ST_OUT_DATA,
        ST_OUT_TAG_HDR,
        ST_OUT_TAG,
        ST_WAIT_AUTH,
        ST_OUT_STATUS
    } pp_state_t;

    // Zero every byte whose valid bit is clear. Valid bit i guards bits
    // [8i+7:8i], so bit 3 guards byte 0 (bits 31:24).
    function automatic logic [31:0] mask_bytes(input logic [31:0] w,
                                               input logic [3:0]  vb);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = vb[i] ? w[i*8 +: 8] : 8'h00;
        end
        return m;
    endfunction

    // Number of valid bytes in a word.
    function automatic logic [2:0] popcount4(input logic [3:0] vb);
        return {2'b00, vb[0]} + {2'b00, vb[1]} + {2'b00, vb[2]} + {2'b00, vb[3]};
    endfunction

endpackage

// File: rtl/bdo_post_processor.sv
// Post-processor of the LWC cipher core. Takes the instruction and segment
// headers from the pre-processor, re-types each header for the host, passes
// the cipher output (PT/CT/tag) straight through with byte masking, and ends
// every ENC/DEC operation with a status word.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cmd/_valid/_ready   instruction and segment-header words
//   bdo/_valid/_ready   cipher output words, bdo_valid_bytes mask (bit 3 =
//                       byte 0), end_of_block marks the last word of a segment
//   msg_auth*           decrypt tag-compare result
//   do_data/_valid/_ready/do_last  output stream to host, do_last on status
module bdo_post_processor
    import lwc_pkg::*;
#(
    parameter int TAG_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] bdo,
    input  logic        bdo_valid,
    input  logic [3:0]  bdo_valid_bytes,
    input  logic        end_of_block,
    output logic        bdo_ready,
    input  logic        msg_auth_valid,
    input  logic        msg_auth,
    output logic        msg_auth_ready,
    output logic [31:0] do_data,
    output logic        do_valid,
    input  logic        do_ready,
    output logic        do_last
);

    localparam logic [2:0]  TAG_LAST     = 3'(TAG_WORDS - 1);
    localparam logic [31:0] TAG_HDR_WORD = {TAG_TYPE, 28'(TAG_WORDS * 4)};

    pp_state_t   state_q, state_d;
    logic [27:0] hdr_q, hdr_d;        // header below the type field
    logic [15:0] rem_q, rem_d;        // bytes still expected in the segment
    logic [2:0]  cnt_q, cnt_d;        // tag words already forwarded
    logic        dec_q, dec_d;
    logic        result_q, result_d;

    logic [15:0] rem_sat;
    pp_state_t   after_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            hdr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hdr_d          = hdr_q;
        rem_d          = rem_q;
        cnt_d          = cnt_q;
        dec_d          = dec_q;
        result_d       = result_q;
        cmd_ready      = 1'b0;
        bdo_ready      = 1'b0;
        msg_auth_ready = 1'b0;
        do_data        = '0;
        do_valid       = 1'b0;
        do_last        = 1'b0;

        // A non-final segment is followed by another header; the final one
        // by the tag (encrypt) or the tag-compare result (decrypt).
        if (!hdr_q[24]) begin
            after_data = ST_GET_HDR;
        end else if (dec_q) begin
            after_data = ST_WAIT_AUTH;
        end else begin
            after_data = ST_OUT_TAG_HDR;
        end

        // Over-reported bytes must not wrap the counter.
        if (rem_q > {13'b0, popcount4(bdo_valid_bytes)}) begin
            rem_sat = rem_q - {13'b0, popcount4(bdo_valid_bytes)};
        end else begin
            rem_sat = '0;
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd[31:28] == OP_ENC || cmd[31:28] == OP_DEC)) begin
                    dec_d   = (cmd[31:28] == OP_DEC);
                    state_d = ST_GET_HDR;
                end
            end
            ST_GET_HDR: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    hdr_d   = cmd[27:0];
                    rem_d   = cmd[15:0];
                    state_d = ST_OUT_HDR;
                end
            end
            ST_OUT_HDR: begin
                do_valid = 1'b1;
                do_data  = {(dec_q ? PT_TYPE : CT_TYPE), hdr_q};
                if (do_ready) begin
                    state_d = (rem_q == 16'd0) ? after_data : ST_OUT_DATA;
                end
            end
            ST_OUT_DATA: begin
                // Combinational pass-through: the host's ready is the
                // cipher's ready, so no word is buffered here.
                do_valid  = bdo_valid;
                bdo_ready = do_ready;
                do_data   = mask_bytes(bdo, bdo_valid_bytes);
                if (bdo_valid && do_ready) begin
                    rem_d = rem_sat;
                    if (rem_sat == 16'd0 || end_of_block) begin
                        state_d = after_data;
                    end
                end
            end
            ST_OUT_TAG_HDR: begin
                do_valid = 1'b1;
                do_data  = TAG_HDR_WORD;
                if (do_ready) begin
                    cnt_d   = '0;
                    state_d = ST_OUT_TAG;
                end
            end
            ST_OUT_TAG: begin
                do_valid  = bdo_valid;
                bdo_ready = do_ready;
                do_data   = bdo;
                if (bdo_valid && do_ready) begin
                    if (cnt_q == TAG_LAST) begin
                        cnt_d    = '0;
                        result_d = 1'b1;
                        state_d  = ST_OUT_STATUS;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_WAIT_AUTH: begin
                msg_auth_ready = 1'b1;
                if (msg_auth_valid) begin
                    result_d = msg_auth;
                    state_d  = ST_OUT_STATUS;
                end
            end
            ST_OUT_STATUS: begin
                do_valid = 1'b1;
                do_last  = 1'b1;
                do_data  = result_q ? STATUS_SUCCESS : STATUS_FAILURE;
                if (do_ready) begin
                    result_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bdo_post_processor.sv
// Self-checking bench for bdo_post_processor: a byte-mask vector table,
// hand-written corner-case operations and randomized multi-segment
// operations compared against an output-stream model.
module tb_bdo_post_processor;

    localparam int TAG_WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cmd = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] bdo = '0;
    logic        bdo_valid = 1'b0;
    logic [3:0]  bdo_valid_bytes = '0;
    logic        end_of_block = 1'b0;
    logic        bdo_ready;
    logic        msg_auth_valid = 1'b0;
    logic        msg_auth = 1'b0;
    logic        msg_auth_ready;
    logic [31:0] do_data;
    logic        do_valid;
    logic        do_ready = 1'b0;
    logic        do_last;

    always #5 clk = ~clk;

    bdo_post_processor #(.TAG_WORDS(TAG_WORDS)) dut (
        .clk(clk), .rst(rst),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .bdo(bdo), .bdo_valid(bdo_valid), .bdo_valid_bytes(bdo_valid_bytes),
        .end_of_block(end_of_block), .bdo_ready(bdo_ready),
        .msg_auth_valid(msg_auth_valid), .msg_auth(msg_auth),
        .msg_auth_ready(msg_auth_ready),
        .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready),
        .do_last(do_last)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        logic        eob;
    } bdo_item_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] want;
    } mask_vec_t;

    bdo_item_t   bdo_q[$];
    logic [31:0] cmd_q[$];
    logic [32:0] got_q[$];   // {do_last, do_data} per accepted word
    logic [32:0] want_q[$];

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;      // 0: always ready, 1: random 50%, 2: held low
    bit auth_pend = 0;
    bit auth_val = 0;
    bit stab_en = 1;
    bit hs_cmd = 0, hs_bdo = 0, hs_auth = 0;
    int valid_cycles = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Byte b of a word is bits [31-8b -: 8] and is kept when mask bit 3-b is set.
    function automatic logic [31:0] model_mask(input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            if (m[3-b]) r[31-8*b -: 8] = d[31-8*b -: 8];
        end
        return r;
    endfunction

    // Monitor: sample at negedge, where inputs and state are both settled.
    always @(negedge clk) begin
        hs_cmd  = cmd_valid && cmd_ready;
        hs_bdo  = bdo_valid && bdo_ready;
        hs_auth = msg_auth_valid && msg_auth_ready;
        if (rst) begin
            if (do_valid) valid_cycles++;
            if (do_valid && do_ready) got_q.push_back({do_last, do_data});
            if (stab_en && prev_stall)
                check("stall_hold", {31'b0, do_valid, do_data}, {31'b0, 1'b1, prev_data});
            prev_stall = stab_en && do_valid && !do_ready;
            prev_data  = do_data;
        end else begin
            prev_stall = 0;
        end
    end

    // Driver: retire accepted words and present the next ones just after posedge.
    always @(posedge clk) begin
        #1;
        if (hs_cmd && cmd_q.size() > 0) cmd_q.delete(0);
        if (hs_bdo && bdo_q.size() > 0) bdo_q.delete(0);
        if (hs_auth) auth_pend = 0;
        hs_cmd = 0; hs_bdo = 0; hs_auth = 0;
        cmd_valid = (cmd_q.size() != 0);
        cmd       = cmd_valid ? cmd_q[0] : 32'h0;
        bdo_valid = (bdo_q.size() != 0);
        if (bdo_valid) begin
            bdo = bdo_q[0].data; bdo_valid_bytes = bdo_q[0].mask; end_of_block = bdo_q[0].eob;
        end else begin
            bdo = '0; bdo_valid_bytes = '0; end_of_block = 1'b0;
        end
        msg_auth_valid = auth_pend;
        msg_auth       = auth_val;
        case (ready_mode)
            0:       do_ready = 1'b1;
            1:       do_ready = 1'($urandom_range(0, 1));
            default: do_ready = 1'b0;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {27'b0, cmd_ready, bdo_ready, msg_auth_ready, do_valid, do_last, do_data},
                    {27'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    endtask

    task automatic flush();
        cmd_q.delete(); bdo_q.delete(); got_q.delete(); want_q.delete();
        auth_pend = 0; hs_cmd = 0; hs_bdo = 0; hs_auth = 0;
    endtask

    task automatic add_segment(input bit is_dec, input bit last, input int len);
        logic [31:0] h;
        bdo_item_t   it;
        int          rem;
        bit          done;
        h = $urandom;
        h[24] = last;
        h[15:0] = 16'(len);
        cmd_q.push_back(h);
        want_q.push_back({1'b0, (is_dec ? 4'h4 : 4'h5), h[27:0]});
        rem  = len;
        done = (len == 0);
        while (!done) begin
            it.data = $urandom;
            it.mask = 4'($urandom);
            it.eob  = ($urandom_range(0, 7) == 0);
            bdo_q.push_back(it);
            want_q.push_back({1'b0, model_mask(it.data, it.mask)});
            rem = rem - $countones(it.mask);
            if (rem < 0) rem = 0;
            done = (rem == 0) || it.eob;
        end
    endtask

    task automatic finish_op(input bit is_dec, input bit auth);
        bdo_item_t it;
        if (!is_dec) begin
            want_q.push_back({1'b0, 32'h8000_0010});
            for (int i = 0; i < TAG_WORDS; i++) begin
                it.data = $urandom;
                it.mask = 4'($urandom);
                it.eob  = (i == TAG_WORDS - 1);
                bdo_q.push_back(it);
                want_q.push_back({1'b0, it.data});
            end
            want_q.push_back({1'b1, 32'hE000_0000});
        end else begin
            auth_val  = auth;
            auth_pend = 1;
            want_q.push_back({1'b1, auth ? 32'hE000_0000 : 32'hF000_0000});
        end
    endtask

    task automatic wait_and_compare(input string name);
        int n;
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            if (got_q.size() >= want_q.size()) break;
        end
        tick(4);
        check($sformatf("%s_count", name), 64'(got_q.size()), 64'(want_q.size()));
        n = (got_q.size() < want_q.size()) ? got_q.size() : want_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_word%0d", name, i), 64'(got_q[i]), 64'(want_q[i]));
        check($sformatf("%s_bdo_drained", name), 64'(bdo_q.size()), 64'd0);
        check($sformatf("%s_cmd_drained", name), 64'(cmd_q.size()), 64'd0);
        got_q.delete(); want_q.delete();
        $display("op %s: %0d words compared", name, n);
    endtask

    task automatic push_bdo(input logic [31:0] d, input logic [3:0] m, input logic e);
        bdo_item_t it;
        it.data = d; it.mask = m; it.eob = e;
        bdo_q.push_back(it);
    endtask

    mask_vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h11223344, 4'b1111, 32'h11223344};
        vecs[1] = '{32'h11223344, 4'b1000, 32'h11000000};
        vecs[2] = '{32'h11223344, 4'b0100, 32'h00220000};
        vecs[3] = '{32'h11223344, 4'b0010, 32'h00003300};
        vecs[4] = '{32'h11223344, 4'b0001, 32'h00000044};
        vecs[5] = '{32'hDEADBEEF, 4'b0000, 32'h00000000};
        vecs[6] = '{32'hDEADBEEF, 4'b1010, 32'hDE00BE00};
        vecs[7] = '{32'hDEADBEEF, 4'b0101, 32'h00AD00EF};
        vecs[8] = '{32'hCAFEF00D, 4'b1110, 32'hCAFEF000};
        vecs[9] = '{32'hCAFEF00D, 4'b0111, 32'h00FEF00D};

        // Reset state
        tick(2);
        check_reset_outputs("reset_state");
        @(posedge clk); #2; rst = 1'b1;
        tick(2);

        // ENC, one segment of 5 bytes
        cmd_q.push_back(32'h2000_0000);
        cmd_q.push_back(32'h4700_0005);
        push_bdo(32'h11223344, 4'b1111, 1'b0);
        push_bdo(32'h55AABBCC, 4'b1000, 1'b1);
        want_q.push_back({1'b0, 32'h5700_0005});
        want_q.push_back({1'b0, 32'h11223344});
        want_q.push_back({1'b0, 32'h55000000});
        want_q.push_back({1'b0, 32'h8000_0010});
        push_bdo(32'hA1A2A3A4, 4'b1111, 1'b0); want_q.push_back({1'b0, 32'hA1A2A3A4});
        push_bdo(32'hB1B2B3B4, 4'b0011, 1'b0); want_q.push_back({1'b0, 32'hB1B2B3B4});
        push_bdo(32'hC1C2C3C4, 4'b1111, 1'b0); want_q.push_back({1'b0, 32'hC1C2C3C4});
        push_bdo(32'hD1D2D3D4, 4'b1111, 1'b1); want_q.push_back({1'b0, 32'hD1D2D3D4});
        want_q.push_back({1'b1, 32'hE000_0000});
        wait_and_compare("enc_len5");

        // DEC, auth failure: CT passes, no tag words, failure status
        cmd_q.push_back(32'h3000_0000);
        cmd_q.push_back(32'h5700_0008);
        push_bdo(32'h01020304, 4'b1111, 1'b0);
        push_bdo(32'h05060708, 4'b1111, 1'b1);
        want_q.push_back({1'b0, 32'h4700_0008});
        want_q.push_back({1'b0, 32'h01020304});
        want_q.push_back({1'b0, 32'h05060708});
        auth_val = 1'b0; auth_pend = 1;
        want_q.push_back({1'b1, 32'hF000_0000});
        wait_and_compare("dec_fail");

        // ENC, length 0: tag words are queued early and must not be taken
        // before the tag header has gone out
        cmd_q.push_back(32'h2000_0000);
        cmd_q.push_back(32'h4700_0000);
        want_q.push_back({1'b0, 32'h5700_0000});
        finish_op(1'b0, 1'b1);
        wait_and_compare("enc_len0");

        // ACTKEY then an invalid opcode: both consumed, nothing emitted
        valid_cycles = 0;
        cmd_q.push_back(32'h7000_0000);
        cmd_q.push_back(32'hF000_0000);
        tick(20);
        check("actkey_no_output", 64'(valid_cycles), 64'd0);
        check("actkey_cmd_consumed", 64'(cmd_q.size()), 64'd0);
        check("actkey_idle_ready", 64'(cmd_ready), 64'd1);

        // Byte-mask table, applied in OUT_DATA with the host stalled
        cmd_q.push_back(32'h2000_0000);
        cmd_q.push_back(32'h4700_FFFF);
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (got_q.size() >= 1) break;
        end
        ready_mode = 2;
        stab_en = 0;
        check("table_hdr_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) check("table_hdr", 64'(got_q[0]), {31'b0, 1'b0, 32'h5700_FFFF});
        for (int i = 0; i < 10; i++) begin
            bdo_q.delete();
            push_bdo(vecs[i].data, vecs[i].mask, 1'b0);
            tick(2);
            check($sformatf("mask_vec%0d", i),
                  {29'b0, do_valid, bdo_ready, do_last, do_data},
                  {29'b0, 1'b1, 1'b0, 1'b0, vecs[i].want});
            $display("vec %0d data=%h mask=%b do_data=%h", i, vecs[i].data, vecs[i].mask, do_data);
        end

        // Asynchronous reset in the middle of OUT_DATA
        @(negedge clk); #2;
        rst = 1'b0;
        flush();
        #1;
        check_reset_outputs("reset_mid_data");
        tick(2);
        check("reset_no_status", 64'(got_q.size()), 64'd0);
        @(posedge clk); #2; rst = 1'b1;
        ready_mode = 0;
        stab_en = 1;
        tick(2);

        // Randomized operations, alternating always-ready and 50% ready
        for (int op = 0; op < 40; op++) begin
            bit is_dec;
            int nseg;
            is_dec = 1'($urandom_range(0, 1));
            nseg = $urandom_range(1, 3);
            ready_mode = (op < 4) ? 0 : $urandom_range(0, 1);
            cmd_q.push_back({(is_dec ? 4'b0011 : 4'b0010), 28'($urandom)});
            for (int s = 0; s < nseg; s++)
                add_segment(is_dec, (s == nseg - 1), $urandom_range(0, 12));
            finish_op(is_dec, 1'($urandom_range(0, 1)));
            wait_and_compare($sformatf("rnd%0d_%s", op, is_dec ? "dec" : "enc"));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
